// File: rtl/o_ddr_tx_pkg.sv
// Shared definitions for the O_DDR transmit scheduler: state encoding,
// the training pair pattern and the pair-counter width helper.
package o_ddr_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TRAIN = 2'd2
    } state_e;

    // Pair driven on every training cycle (rising-edge bit 1, falling-edge bit 0).
    localparam logic [1:0] TRAIN_PATTERN = 2'b01;

    // Width of a counter that indexes 0..pairs-1, never narrower than one bit.
    function automatic int cnt_width(input int pairs);
        return (pairs > 1) ? $clog2(pairs) : 1;
    endfunction

endpackage

// File: rtl/o_ddr_tx_skid.sv
// Two-entry word buffer for the O_DDR transmit scheduler.
// The head entry is the word currently being (or about to be) serialized,
// the tail entry is the hold word queued behind it. The head stays valid
// until the scheduler pops it on the word's last pair, so "full" means one
// word on the wire plus one waiting. The ready output is registered and is
// computed from next-state occupancy so it never promises a slot that is gone.
module o_ddr_tx_skid #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             block_i,
    input  logic             pop_i,
    output logic             peek_vld_o,
    output logic [WIDTH-1:0] peek_o
);

    logic             head_vld_q, head_vld_d;
    logic             tail_vld_q, tail_vld_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             ready_q;
    logic             accept;

    assign accept = valid_i && ready_q;

    // Next occupancy: a pop promotes the tail, an accept fills the first free slot.
    always_comb begin
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (pop_i) begin
            if (tail_vld_q) begin
                head_d     = tail_q;
                head_vld_d = 1'b1;
                tail_vld_d = accept;
                tail_d     = data_i;
            end else begin
                head_vld_d = accept;
                head_d     = data_i;
            end
        end else if (accept) begin
            if (!head_vld_q) begin
                head_vld_d = 1'b1;
                head_d     = data_i;
            end else begin
                tail_vld_d = 1'b1;
                tail_d     = data_i;
            end
        end
    end

    // Entry valid flags and the registered ready; reset drops any buffered word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            ready_q    <= !(head_vld_d && tail_vld_d) && !block_i;
        end
    end

    // Word storage; contents are only meaningful while the matching flag is set.
    always_ff @(posedge clk_i) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign ready_o    = ready_q;
    assign peek_vld_o = head_vld_q;
    assign peek_o     = head_q;

endmodule

// File: rtl/o_ddr_tx_sched.sv
// Transmit scheduler / serializer feeding one O_DDR output cell.
// Words are sent LSB pair first, one pair per clock, back-to-back when the
// hold word is ready. ENABLE low freezes the serializer and drops E_OUT one
// cycle later, aligned with D_OUT. Define O_DDR_TRAIN_EN to build the
// training burst (TRAIN_PAIRS cycles of 2'b01 followed by a TRAIN_DONE pulse);
// without it TRAIN_REQ is ignored and TRAIN_DONE stays low.
module o_ddr_tx_sched
    import o_ddr_tx_pkg::*;
#(
    parameter int   WIDTH       = 16,
    parameter logic IDLE_LEVEL  = 1'b0,
    parameter int   TRAIN_PAIRS = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             DATA_VALID,
    output logic             DATA_READY,
    input  logic             ENABLE,
    input  logic             TRAIN_REQ,
    output logic [1:0]       D_OUT,
    output logic             E_OUT,
    output logic             BUSY,
    output logic             TRAIN_DONE
);

    localparam int            PAIRS     = WIDTH / 2;
    localparam int            CW        = cnt_width(PAIRS);
    localparam logic [CW-1:0] LAST      = CW'(PAIRS - 1);
    localparam logic [1:0]    IDLE_PAIR = {2{IDLE_LEVEL}};

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] src_word;
    logic [1:0]       d_out_q;
    logic             e_out_q;
    logic             busy_q;
    logic             done_q;

    logic             head_vld;
    logic [WIDTH-1:0] head_word;
    logic             from_head;
    logic             can_emit;
    logic             pop;
    logic             train_start;
    logic             train_end;
    logic             train_next;

    o_ddr_tx_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk_i      (C),
        .rst_ni     (R),
        .data_i     (DATA_IN),
        .valid_i    (DATA_VALID),
        .ready_o    (DATA_READY),
        .block_i    (train_next),
        .pop_i      (pop),
        .peek_vld_o (head_vld),
        .peek_o     (head_word)
    );

`ifdef O_DDR_TRAIN_EN
    localparam int             TCW        = $clog2(TRAIN_PAIRS + 1);
    localparam logic [TCW-1:0] TRAIN_LAST = TCW'(TRAIN_PAIRS);

    logic [TCW-1:0] tcnt_q;

    // Training wins over a pending word, but only once the line is idle.
    assign train_start = ENABLE && (state_q == ST_IDLE) && TRAIN_REQ;
    assign train_end   = ENABLE && (state_q == ST_TRAIN) && (tcnt_q == TRAIN_LAST);
    assign train_next  = train_start || ((state_q == ST_TRAIN) && !train_end);

    // Counts training pairs already driven; the entry edge drives the first one.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            tcnt_q <= '0;
        end else if (train_start) begin
            tcnt_q <= TCW'(1);
        end else if (ENABLE && (state_q == ST_TRAIN)) begin
            tcnt_q <= train_end ? '0 : tcnt_q + 1'b1;
        end
    end
`else
    logic unused_train;

    assign unused_train = TRAIN_REQ ^ (TRAIN_PAIRS < 1);
    assign train_start  = 1'b0;
    assign train_end    = 1'b0;
    assign train_next   = 1'b0;
`endif

    // Pair 0 comes straight from the buffer head; later pairs from the shifter.
    assign from_head = (cnt_q == '0);
    assign src_word  = from_head ? head_word : shift_q;
    assign can_emit  = ENABLE && !train_start && (state_q != ST_TRAIN) &&
                       (!from_head || head_vld);
    // The word leaves the buffer on its last pair, so the counter wraps as the next word loads.
    assign pop       = can_emit && (cnt_q == LAST);

    // Scheduler FSM with registered line outputs; ENABLE low holds everything but E_OUT.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            d_out_q <= IDLE_PAIR;
            e_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            e_out_q <= ENABLE;
            done_q  <= train_end;
            if (train_start) begin
                state_q <= ST_TRAIN;
                d_out_q <= TRAIN_PATTERN;
                busy_q  <= 1'b1;
            end else if (can_emit) begin
                state_q <= ST_DATA;
                d_out_q <= src_word[1:0];
                cnt_q   <= pop ? '0 : cnt_q + 1'b1;
                busy_q  <= 1'b1;
            end else if (ENABLE && (state_q == ST_TRAIN)) begin
                if (train_end) begin
                    state_q <= ST_IDLE;
                    d_out_q <= IDLE_PAIR;
                    busy_q  <= 1'b0;
                end else begin
                    d_out_q <= TRAIN_PATTERN;
                end
            end else if (ENABLE) begin
                state_q <= ST_IDLE;
                d_out_q <= IDLE_PAIR;
                busy_q  <= 1'b0;
            end
        end
    end

    // Shifter keeps the not-yet-sent pairs of the current word.
    always_ff @(posedge C) begin
        if (can_emit) begin
            shift_q <= src_word >> 2;
        end
    end

    assign D_OUT      = d_out_q;
    assign E_OUT      = e_out_q;
    assign BUSY       = busy_q;
    assign TRAIN_DONE = done_q;

endmodule

// File: tb/tb_o_ddr_tx_sched.sv
// Directed testbench for o_ddr_tx_sched (WIDTH=16, IDLE_LEVEL=0, TRAIN_PAIRS=8).
// Training expectations follow the O_DDR_TRAIN_EN build macro.
module tb_o_ddr_tx_sched;

    localparam int WIDTH = 16;

    logic             C          = 1'b0;
    logic             R          = 1'b0;
    logic [WIDTH-1:0] DATA_IN    = '0;
    logic             DATA_VALID = 1'b0;
    logic             ENABLE     = 1'b0;
    logic             TRAIN_REQ  = 1'b0;
    logic             DATA_READY;
    logic [1:0]       D_OUT;
    logic             E_OUT;
    logic             BUSY;
    logic             TRAIN_DONE;

    int n_checks = 0;
    int n_fail   = 0;

    o_ddr_tx_sched #(
        .WIDTH       (WIDTH),
        .IDLE_LEVEL  (1'b0),
        .TRAIN_PAIRS (8)
    ) dut (
        .C          (C),
        .R          (R),
        .DATA_IN    (DATA_IN),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .ENABLE     (ENABLE),
        .TRAIN_REQ  (TRAIN_REQ),
        .D_OUT      (D_OUT),
        .E_OUT      (E_OUT),
        .BUSY       (BUSY),
        .TRAIN_DONE (TRAIN_DONE)
    );

    always #5 C = ~C;

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] pair_of(input logic [15:0] w, input int k);
        return w[2*k +: 2];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  exp_a5c3 [8];
        logic [15:0] words [3];
        logic [15:0] w;
        logic        rdy;
        logic        saw_low;
        logic        started;
        int          wi;
        int          pi;

        exp_a5c3 = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10};

        // 1: reset values, then release
        ENABLE = 1'b1;
        tick();
        tick();
        check("rst_dout",  32'(D_OUT), 32'd0);
        check("rst_eout",  32'(E_OUT), 32'd0);
        check("rst_ready", 32'(DATA_READY), 32'd0);
        check("rst_busy",  32'(BUSY), 32'd0);
        check("rst_done",  32'(TRAIN_DONE), 32'd0);
        R = 1'b1;
        tick();
        check("rel_ready", 32'(DATA_READY), 32'd1);
        check("rel_eout",  32'(E_OUT), 32'd1);
        check("rel_dout",  32'(D_OUT), 32'd0);
        check("rel_busy",  32'(BUSY), 32'd0);

        // 2: single word 16'hA5C3
        check("t2_ready", 32'(DATA_READY), 32'd1);
        DATA_IN    = 16'hA5C3;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        check("t2_acc_dout", 32'(D_OUT), 32'd0);
        check("t2_acc_busy", 32'(BUSY), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("t2_pair%0d", k), 32'(D_OUT), 32'(exp_a5c3[k]));
            check($sformatf("t2_busy%0d", k), 32'(BUSY), 32'd1);
        end
        tick();
        check("t2_end_dout", 32'(D_OUT), 32'd0);
        check("t2_end_busy", 32'(BUSY), 32'd0);

        // 3: three words back-to-back with DATA_VALID held high
        words      = '{16'h1234, 16'hBEEF, 16'h0F0F};
        wi         = 0;
        pi         = 0;
        saw_low    = 1'b0;
        started    = 1'b0;
        DATA_IN    = words[0];
        DATA_VALID = 1'b1;
        for (int cyc = 0; cyc < 40 && pi < 24; cyc++) begin
            rdy = DATA_READY;
            tick();
            if (DATA_VALID && rdy) begin
                wi++;
                if (wi < 3) DATA_IN = words[wi];
                else DATA_VALID = 1'b0;
            end
            if (!DATA_READY) saw_low = 1'b1;
            if (BUSY) started = 1'b1;
            if (started) begin
                check($sformatf("t3_pair%0d", pi), 32'(D_OUT), 32'(pair_of(words[pi/8], pi%8)));
                pi++;
            end
        end
        DATA_VALID = 1'b0;
        check("t3_pair_count", 32'(pi), 32'd24);
        check("t3_ready_low",  32'(saw_low), 32'd1);
        tick();
        check("t3_end_dout", 32'(D_OUT), 32'd0);
        check("t3_end_busy", 32'(BUSY), 32'd0);

        // 4: ENABLE low for 3 cycles mid-word
        w          = 16'h1B6C;
        DATA_IN    = w;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t4_pre%0d", k), 32'(D_OUT), 32'(pair_of(w, k)));
        end
        ENABLE = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t4_stall_eout%0d", k), 32'(E_OUT), 32'd0);
            check($sformatf("t4_stall_dout%0d", k), 32'(D_OUT), 32'(pair_of(w, 2)));
        end
        ENABLE = 1'b1;
        for (int k = 3; k < 8; k++) begin
            tick();
            check($sformatf("t4_eout%0d", k), 32'(E_OUT), 32'd1);
            check($sformatf("t4_post%0d", k), 32'(D_OUT), 32'(pair_of(w, k)));
        end
        tick();
        check("t4_end_dout", 32'(D_OUT), 32'd0);
        check("t4_end_busy", 32'(BUSY), 32'd0);

        // 5: TRAIN_REQ together with a word
        DATA_IN    = 16'hA5C3;
        DATA_VALID = 1'b1;
        TRAIN_REQ  = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        TRAIN_REQ  = 1'b0;
`ifdef O_DDR_TRAIN_EN
        check("t5_ready_train", 32'(DATA_READY), 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            check($sformatf("t5_train%0d", k), 32'(D_OUT), 32'd1);
            check($sformatf("t5_tdone%0d", k), 32'(TRAIN_DONE), 32'd0);
        end
        tick();
        check("t5_done_pulse", 32'(TRAIN_DONE), 32'd1);
        check("t5_done_dout",  32'(D_OUT), 32'd0);
        check("t5_done_busy",  32'(BUSY), 32'd0);
`else
        check("t5_acc_dout", 32'(D_OUT), 32'd0);
`endif
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("t5_pair%0d", k), 32'(D_OUT), 32'(exp_a5c3[k]));
            check($sformatf("t5_nodone%0d", k), 32'(TRAIN_DONE), 32'd0);
        end
        tick();
        check("t5_end_busy", 32'(BUSY), 32'd0);

        // 6: reset asserted while pair 3 is on the line
        DATA_IN    = 16'hA5C3;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("t6_pair3", 32'(D_OUT), 32'(exp_a5c3[3]));
        R = 1'b0;
        #1;
        check("t6_rst_dout",  32'(D_OUT), 32'd0);
        check("t6_rst_eout",  32'(E_OUT), 32'd0);
        check("t6_rst_ready", 32'(DATA_READY), 32'd0);
        check("t6_rst_busy",  32'(BUSY), 32'd0);
        tick();
        @(negedge C);
        R = 1'b1;
        tick();
        check("t6_rel_ready", 32'(DATA_READY), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t6_idle_dout%0d", k), 32'(D_OUT), 32'd0);
            check($sformatf("t6_idle_busy%0d", k), 32'(BUSY), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
